vram_dbuf_ctrl: RTL and testbench

- Parametrised, double-buffered VRAM controller: successor to the single-page dual-clock VRAM.
- Single-ported array of 2 pages x 2^ADDR_W words; one access per cycle, with arbitration between the VGA scanout reader, an optional hardware fill engine and the GPU request port.
- Scanout reads the front page; the GPU and the fill engine access the back page.
- Page swap is requested by the GPU and applied only at the rising edge of vblank, giving tear-free frames.

---
 rtl/vram_dbuf_ctrl_if.sv | 54 +++++
 rtl/vram_dbuf_ctrl.sv | 155 +++++++++++++++
 tb/tb_vram_dbuf_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_dbuf_ctrl_if.sv
// Bus bundle for vram_dbuf_ctrl: GPU request port, VGA scanout port and page-swap control.
// The fill-engine signals exist only when VRAM_FILL_EN is defined.
interface vram_dbuf_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
);
    // GPU handshake: an access is accepted in a cycle where gpu_req && gpu_ready; gpu_ready does not
    // depend on gpu_req, and a refused request must be held unchanged until accepted. Reads answer
    // with a one-cycle gpu_rvalid pulse after the accepting edge; writes produce no response.
    logic              gpu_req;
    logic              gpu_we;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_data_in;
    logic              gpu_ready;
    logic [DATA_W-1:0] gpu_rdata;
    logic              gpu_rvalid;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_pixel_out;
    logic              vga_valid;
    logic              vblank;
    logic              swap_req;
    logic              swap_pending;
    logic              front_page;
`ifdef VRAM_FILL_EN
    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;

    modport slave (
        input  gpu_req, gpu_we, gpu_addr, gpu_data_in, vga_req, vga_addr, vblank, swap_req,
               fill_start, fill_value,
        output gpu_ready, gpu_rdata, gpu_rvalid, vga_pixel_out, vga_valid, swap_pending,
               front_page, fill_busy
    );
    modport master (
        output gpu_req, gpu_we, gpu_addr, gpu_data_in, vga_req, vga_addr, vblank, swap_req,
               fill_start, fill_value,
        input  gpu_ready, gpu_rdata, gpu_rvalid, vga_pixel_out, vga_valid, swap_pending,
               front_page, fill_busy
    );
`else
    modport slave (
        input  gpu_req, gpu_we, gpu_addr, gpu_data_in, vga_req, vga_addr, vblank, swap_req,
        output gpu_ready, gpu_rdata, gpu_rvalid, vga_pixel_out, vga_valid, swap_pending,
               front_page
    );
    modport master (
        output gpu_req, gpu_we, gpu_addr, gpu_data_in, vga_req, vga_addr, vblank, swap_req,
        input  gpu_ready, gpu_rdata, gpu_rvalid, vga_pixel_out, vga_valid, swap_pending,
               front_page
    );
`endif
endinterface

// File: rtl/vram_dbuf_ctrl.sv
// Double-buffered single-port VRAM: scanout reads the front page, GPU/fill use the back page,
// and page swaps apply on the vblank rising edge. Optional fill engine: define VRAM_FILL_EN.
module vram_dbuf_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
) (
    input  logic                 clk_gpu,
    input  logic                 rst,
    vram_dbuf_ctrl_if.slave      bus,
    output logic [1:0]           o_dbg_state
);
    localparam int PA_W = ADDR_W + 1;

    typedef enum logic { SWAP_IDLE, SWAP_ARMED } swap_state_t;

    swap_state_t       r_swap_state, w_swap_next;
    logic              r_front;
    logic              r_vblank_q;
    logic              w_vb_rise;
    logic              w_toggle;
    logic              w_fill_busy;
    logic [PA_W-1:0]   w_fill_addr;
    logic [DATA_W-1:0] w_fill_data;
    logic [PA_W-1:0]   w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_mem_we;
    logic              w_gpu_acc;
    logic              r_vga_valid;
    logic [DATA_W-1:0] r_vga_pixel;
    logic              r_gpu_rvalid;
    logic [DATA_W-1:0] r_gpu_rdata;
    logic [DATA_W-1:0] r_mem [0:(1 << PA_W)-1];

    assign w_vb_rise = bus.vblank && !r_vblank_q;

`ifdef VRAM_FILL_EN
    typedef enum logic { FILL_IDLE, FILL_BUSY } fill_state_t;

    fill_state_t       r_fill_state, w_fill_next;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic              r_fill_page;
    logic [DATA_W-1:0] r_fill_val;
    logic              w_fill_step;

    always_comb begin
        w_fill_next = r_fill_state;
        w_fill_step = 1'b0;
        case (r_fill_state)
            FILL_IDLE: if (bus.fill_start) w_fill_next = FILL_BUSY;
            FILL_BUSY: begin
                // Scanout owns the array this cycle: the counter simply waits.
                if (!bus.vga_req) begin
                    w_fill_step = 1'b1;
                    if (&r_fill_cnt) w_fill_next = FILL_IDLE;
                end
            end
            default: w_fill_next = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk_gpu or posedge rst) begin
        if (rst) begin
            r_fill_state <= FILL_IDLE;
            r_fill_cnt   <= '0;
            r_fill_page  <= 1'b0;
            r_fill_val   <= '0;
        end else begin
            r_fill_state <= w_fill_next;
            if (r_fill_state == FILL_IDLE && bus.fill_start) begin
                r_fill_cnt  <= '0;
                r_fill_page <= ~r_front;
                r_fill_val  <= bus.fill_value;
            end else if (w_fill_step) begin
                r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
            end
        end
    end

    assign w_fill_busy   = (r_fill_state == FILL_BUSY);
    assign w_fill_addr   = {r_fill_page, r_fill_cnt};
    assign w_fill_data   = r_fill_val;
    assign bus.fill_busy = w_fill_busy;
`else
    assign w_fill_busy = 1'b0;
    assign w_fill_addr = '0;
    assign w_fill_data = '0;
`endif

    always_comb begin
        w_swap_next = r_swap_state;
        w_toggle    = 1'b0;
        case (r_swap_state)
            SWAP_IDLE:  if (bus.swap_req) w_swap_next = SWAP_ARMED;
            SWAP_ARMED: begin
                // A running fill keeps the back page busy, so the swap waits for a later edge.
                if (w_vb_rise && !w_fill_busy) begin
                    w_swap_next = SWAP_IDLE;
                    w_toggle    = 1'b1;
                end
            end
            default: w_swap_next = SWAP_IDLE;
        endcase
    end

    assign bus.gpu_ready = !bus.vga_req && !w_fill_busy;
    assign w_gpu_acc     = bus.gpu_req && bus.gpu_ready;

    // Single array port: scanout, then fill, then GPU.
    always_comb begin
        w_addr   = {~r_front, bus.gpu_addr};
        w_wdata  = bus.gpu_data_in;
        w_mem_we = w_gpu_acc && bus.gpu_we;
        if (bus.vga_req) begin
            w_addr   = {r_front, bus.vga_addr};
            w_mem_we = 1'b0;
        end else if (w_fill_busy) begin
            w_addr   = w_fill_addr;
            w_wdata  = w_fill_data;
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk_gpu) begin
        if (w_mem_we && !rst) r_mem[w_addr] <= w_wdata;
    end

    always_ff @(posedge clk_gpu or posedge rst) begin
        if (rst) begin
            r_swap_state <= SWAP_IDLE;
            r_front      <= 1'b0;
            r_vblank_q   <= 1'b0;
            r_vga_valid  <= 1'b0;
            r_vga_pixel  <= '0;
            r_gpu_rvalid <= 1'b0;
            r_gpu_rdata  <= '0;
        end else begin
            r_swap_state <= w_swap_next;
            r_front      <= r_front ^ w_toggle;
            r_vblank_q   <= bus.vblank;
            r_vga_valid  <= bus.vga_req;
            if (bus.vga_req) r_vga_pixel <= r_mem[w_addr];
            r_gpu_rvalid <= w_gpu_acc && !bus.gpu_we;
            if (w_gpu_acc && !bus.gpu_we) r_gpu_rdata <= r_mem[w_addr];
        end
    end

    assign bus.vga_pixel_out = r_vga_pixel;
    assign bus.vga_valid     = r_vga_valid;
    assign bus.gpu_rdata     = r_gpu_rdata;
    assign bus.gpu_rvalid    = r_gpu_rvalid;
    assign bus.front_page    = r_front;
    assign bus.swap_pending  = (r_swap_state == SWAP_ARMED);
    assign o_dbg_state       = {w_fill_busy, r_swap_state == SWAP_ARMED};

endmodule

// File: tb/tb_vram_dbuf_ctrl.sv
// Directed bench for vram_dbuf_ctrl: reset, GPU/VGA access, arbitration, tear-free swap
// and, when VRAM_FILL_EN is defined, the fill engine on a 16-word page.
module tb_vram_dbuf_ctrl;
`ifdef VRAM_FILL_EN
  localparam int AW = 4;
`else
  localparam int AW = 17;
`endif
  localparam int DW = 8;
  localparam int A_RW = (AW > 4) ? 'h10 : 'hA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic exp_front = 1'b0;
  int n_busy;

  vram_dbuf_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  vram_dbuf_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_gpu     (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    #1;
    while (!bus.gpu_ready && k < 50) begin
      step();
      #1;
      k++;
    end
    if (k >= 50) check("gpu_ready_timeout", 32'(bus.gpu_ready), 32'd1);
  endtask

  task automatic gpu_write(input int a, input int d);
    bus.gpu_req = 1'b1;
    bus.gpu_we = 1'b1;
    bus.gpu_addr = AW'(a);
    bus.gpu_data_in = DW'(d);
    wait_ready();
    step();
    bus.gpu_req = 1'b0;
    bus.gpu_we = 1'b0;
  endtask

  task automatic gpu_read(input string tag, input int a);
    bus.gpu_req = 1'b1;
    bus.gpu_we = 1'b0;
    bus.gpu_addr = AW'(a);
    wait_ready();
    step();
    bus.gpu_req = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.gpu_rvalid), 32'd1);
    check({tag, "_rdata"}, 32'(bus.gpu_rdata), 32'(exp_q.pop_front()));
  endtask

  task automatic vga_read(input string tag, input int a, input int exp);
    bus.vga_req = 1'b1;
    bus.vga_addr = AW'(a);
    step();
    bus.vga_req = 1'b0;
    check({tag, "_valid"}, 32'(bus.vga_valid), 32'd1);
    check({tag, "_pixel"}, 32'(bus.vga_pixel_out), 32'(exp));
    step();
    check({tag, "_valid_pulse"}, 32'(bus.vga_valid), 32'd0);
  endtask

  task automatic check_swap(input string tag, input logic pend);
    check({tag, "_front"}, 32'(bus.front_page), 32'(exp_front));
    check({tag, "_pending"}, 32'(bus.swap_pending), 32'(pend));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vga_pixel"}, 32'(bus.vga_pixel_out), 32'd0);
    check({tag, "_vga_valid"}, 32'(bus.vga_valid), 32'd0);
    check({tag, "_gpu_rdata"}, 32'(bus.gpu_rdata), 32'd0);
    check({tag, "_gpu_rvalid"}, 32'(bus.gpu_rvalid), 32'd0);
    check({tag, "_front"}, 32'(bus.front_page), 32'd0);
    check({tag, "_pending"}, 32'(bus.swap_pending), 32'd0);
`ifdef VRAM_FILL_EN
    check({tag, "_fill_busy"}, 32'(bus.fill_busy), 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.gpu_req = 1'b0;
    bus.gpu_we = 1'b0;
    bus.gpu_addr = '0;
    bus.gpu_data_in = '0;
    bus.vga_req = 1'b0;
    bus.vga_addr = '0;
    bus.vblank = 1'b0;
    bus.swap_req = 1'b0;
`ifdef VRAM_FILL_EN
    bus.fill_start = 1'b0;
    bus.fill_value = '0;
`endif
    repeat (2) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    // Back page is 1: stage data for the swap test.
    gpu_write(A_RW, 'h5A);
    gpu_write(5, 'h3C);
    check_swap("pre_swap", 1'b0);

    // Swap armed, vblank rises 10 cycles later; a second request while armed is ignored.
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    check_swap("armed", 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.swap_req = (i == 4);
      step();
      check_swap("armed_wait", 1'b1);
    end
    bus.swap_req = 1'b0;
    bus.vblank = 1'b1;
    step();
    exp_front = 1'b1;
    check_swap("swap_edge", 1'b0);
    repeat (2) step();
    bus.vblank = 1'b0;
    step();
    bus.vblank = 1'b1;
    step();
    check_swap("no_double_toggle", 1'b0);
    bus.vblank = 1'b0;
    step();
    vga_read("vga_after_swap", 5, 'h3C);

    // Back page is now 0.
    gpu_write(A_RW, 'hA5);
    exp_q.push_back(8'hA5);
    gpu_read("gpu_rd", A_RW);
    step();
    check("gpu_rvalid_pulse", 32'(bus.gpu_rvalid), 32'd0);
    check("gpu_rdata_hold", 32'(bus.gpu_rdata), 32'hA5);
    vga_read("vga_front", A_RW, 'h5A);

    // Arbitration: VGA wins for three cycles, the held GPU read goes on the fourth.
    bus.gpu_req = 1'b1;
    bus.gpu_we = 1'b0;
    bus.gpu_addr = AW'(A_RW);
    for (int i = 0; i < 3; i++) begin
      bus.vga_req = 1'b1;
      bus.vga_addr = AW'((i == 1) ? A_RW : 5);
      exp_q.push_back((i == 1) ? 8'h5A : 8'h3C);
      #1;
      check("arb_gpu_ready", 32'(bus.gpu_ready), 32'd0);
      step();
      check("arb_vga_valid", 32'(bus.vga_valid), 32'd1);
      check("arb_vga_pixel", 32'(bus.vga_pixel_out), 32'(exp_q.pop_front()));
      check("arb_gpu_stalled", 32'(bus.gpu_rvalid), 32'd0);
    end
    bus.vga_req = 1'b0;
    #1;
    check("arb_gpu_ready_free", 32'(bus.gpu_ready), 32'd1);
    step();
    bus.gpu_req = 1'b0;
    check("arb_gpu_rvalid", 32'(bus.gpu_rvalid), 32'd1);
    check("arb_gpu_rdata", 32'(bus.gpu_rdata), 32'hA5);
    check("arb_vga_idle", 32'(bus.vga_valid), 32'd0);

    // swap_req coincident with the vblank rise arms only.
    bus.swap_req = 1'b1;
    bus.vblank = 1'b1;
    step();
    bus.swap_req = 1'b0;
    check_swap("coincident", 1'b1);
    repeat (2) step();
    check_swap("coincident_hold", 1'b1);
    bus.vblank = 1'b0;
    step();
    bus.vblank = 1'b1;
    step();
    exp_front = 1'b0;
    check_swap("coincident_next_rise", 1'b0);
    bus.vblank = 1'b0;
    step();

`ifdef VRAM_FILL_EN
    // Fill back page 1 with 0x7E; scanout steals two cycles; swap armed mid-fill.
    bus.fill_value = 8'h7E;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    check("fill_busy_start", 32'(bus.fill_busy), 32'd1);
    bus.gpu_req = 1'b1;
    bus.gpu_we = 1'b0;
    bus.gpu_addr = '0;
    n_busy = 1;
    for (int i = 0; i < 40 && bus.fill_busy; i++) begin
      bus.vga_req = (i == 5 || i == 6);
      bus.swap_req = (i == 3);
      bus.vblank = (i == 8);
      #1;
      check("fill_gpu_ready", 32'(bus.gpu_ready), 32'd0);
      step();
      check("fill_gpu_stalled", 32'(bus.gpu_rvalid), 32'd0);
      if (bus.fill_busy) n_busy++;
    end
    bus.vga_req = 1'b0;
    bus.swap_req = 1'b0;
    bus.vblank = 1'b0;
    check("fill_busy_cycles", 32'(n_busy), 32'd18);
    check_swap("fill_swap_held", 1'b1);
    step();
    bus.gpu_req = 1'b0;
    check("fill_gpu_released", 32'(bus.gpu_rvalid), 32'd1);
    check("fill_gpu_rdata", 32'(bus.gpu_rdata), 32'h7E);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h7E);
      gpu_read("fill_word", i);
    end
    bus.vblank = 1'b1;
    step();
    exp_front = 1'b1;
    check_swap("fill_swap_applied", 1'b0);
    bus.vblank = 1'b0;
    step();
`endif

    // Mid-run asynchronous reset with a swap armed and reads in flight.
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    bus.vblank = 1'b1;
    step();
    exp_front = ~exp_front;
    check_swap("final_swap", 1'b0);
    bus.vblank = 1'b0;
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    check_swap("final_armed", 1'b1);
    bus.vga_req = 1'b1;
    bus.vga_addr = '0;
    step();
    bus.vga_req = 1'b0;
    check("pre_reset_vga_valid", 32'(bus.vga_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    step();
    rst = 1'b0;
    step();
    check_outputs_zero("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
